// File: rtl/operand_fetch.sv
// operand_fetch: decode / operand-fetch pipeline stage.
//
// Takes one RV32I instruction per cycle from fetch over a valid/ready
// handshake. It decodes the register fields and immediate, reads the
// register file, and forwards a same-cycle writeback. A per-register
// scoreboard tracks outstanding destination writes, and the stage stalls on
// RAW/WAW hazards. The decoded result sits in one output register with a
// valid/ready handshake toward execute.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc   fetch handshake and payload
//   rf_rd{1,2}_en/_index/_data     register file read ports (data is combinational)
//   wb_en/wb_index/wb_data         writeback bus (also the register file write port)
//   flush                          squash the held output instruction
//   out_valid/out_ready            execute handshake
//   out_pc/out_instr/out_op1/out_op2/out_imm/out_rd/out_rd_we/out_illegal
//                                  registered decode results
module operand_fetch #(
  parameter  int WIDTH = 32,
  parameter  int SIZE  = 32,
  localparam int IDX   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             rf_rd1_en,
  output logic [IDX-1:0]   rf_rd1_index,
  input  logic [WIDTH-1:0] rf_rd1_data,
  output logic             rf_rd2_en,
  output logic [IDX-1:0]   rf_rd2_index,
  input  logic [WIDTH-1:0] rf_rd2_data,
  input  logic             wb_en,
  input  logic [IDX-1:0]   wb_index,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [31:0]      out_imm,
  output logic [IDX-1:0]   out_rd,
  output logic             out_rd_we,
  output logic             out_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J     = 7'b1101111;

  logic [6:0]       w_opcode;
  logic [IDX-1:0]   w_rs1;
  logic [IDX-1:0]   w_rs2;
  logic [IDX-1:0]   w_rd;
  logic             w_useRs1;
  logic             w_useRs2;
  logic             w_writesRd;
  logic             w_illegal;
  logic [31:0]      w_imm;
  logic             w_rd1En;
  logic             w_rd2En;
  logic             w_rdWe;
  logic             w_fwd1;
  logic             w_fwd2;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_outBusy;
  logic             w_accept;
  logic [SIZE-1:0]  w_pendingNext;
  logic [SIZE-1:0]  r_pending;

  // Register fields are taken from their RV32I bit positions. The low IDX
  // bits of each 5-bit field are used, which covers the full field when
  // SIZE is 32.
  assign w_opcode = in_instr[6:0];
  assign w_rs1    = in_instr[15 +: IDX];
  assign w_rs2    = in_instr[20 +: IDX];
  assign w_rd     = in_instr[7 +: IDX];

  // Format decode: this block works out which fields the instruction uses
  // and builds the sign-extended immediate. An unknown opcode reads nothing,
  // writes nothing and is flagged illegal.
  always_comb begin
    w_useRs1   = 1'b0;
    w_useRs2   = 1'b0;
    w_writesRd = 1'b0;
    w_illegal  = 1'b0;
    w_imm      = '0;
    case (w_opcode)
      OP_R: begin
        w_useRs1   = 1'b1;
        w_useRs2   = 1'b1;
        w_writesRd = 1'b1;
      end
      OP_I_ALU, OP_LOAD, OP_JALR: begin
        w_useRs1   = 1'b1;
        w_writesRd = 1'b1;
        w_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_S: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_imm    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_B: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_writesRd = 1'b1;
        w_imm      = {in_instr[31:12], 12'b0};
      end
      OP_J: begin
        w_writesRd = 1'b1;
        w_imm      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // x0 is never read or written, so it never takes part in a hazard.
  assign w_rd1En = w_useRs1 && (w_rs1 != '0);
  assign w_rd2En = w_useRs2 && (w_rs2 != '0);
  assign w_rdWe  = w_writesRd && (w_rd != '0);

  assign rf_rd1_en    = w_rd1En;
  assign rf_rd1_index = w_rs1;
  assign rf_rd2_en    = w_rd2En;
  assign rf_rd2_index = w_rs2;

  // The register file is written on this same edge, so its read data is
  // still stale. A matching writeback is taken straight off the bus instead.
  assign w_fwd1 = wb_en && (wb_index == w_rs1) && w_rd1En;
  assign w_fwd2 = wb_en && (wb_index == w_rs2) && w_rd2En;
  assign w_op1  = !w_rd1En ? '0 : (w_fwd1 ? wb_data : rf_rd1_data);
  assign w_op2  = !w_rd2En ? '0 : (w_fwd2 ? wb_data : rf_rd2_data);

  // A forwarded source resolves RAW. WAW gets no such exemption, so a
  // destination that is still pending always stalls, even if it is being
  // written back this cycle.
  assign w_raw1    = w_rd1En && r_pending[w_rs1] && !w_fwd1;
  assign w_raw2    = w_rd2En && r_pending[w_rs2] && !w_fwd2;
  assign w_waw     = w_rdWe && r_pending[w_rd];
  assign w_outBusy = out_valid && !out_ready;
  assign in_ready  = !(w_raw1 || w_raw2 || w_waw || w_outBusy || flush);
  assign w_accept  = in_valid && in_ready;

  // Scoreboard next state. A writeback or a flush of the held instruction
  // clears a bit. The set from a newly accepted instruction is applied last,
  // so it wins when it hits the same register.
  always_comb begin
    w_pendingNext = r_pending;
    if (wb_en && (wb_index != '0)) begin
      w_pendingNext[wb_index] = 1'b0;
    end
    if (flush && out_valid && out_rd_we) begin
      w_pendingNext[out_rd] = 1'b0;
    end
    if (w_accept && w_rdWe) begin
      w_pendingNext[w_rd] = 1'b1;
    end
  end

  // Scoreboard register. Reset drops every outstanding write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  // Output pipeline register. Flush has priority over everything else. A
  // consume in the same cycle as an accept keeps the register full. The
  // payload only loads on accept, so it stays stable while execute stalls.
  // out_rd reports the destination only for formats that have one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (w_accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        out_pc      <= in_pc;
        out_instr   <= in_instr;
        out_op1     <= w_op1;
        out_op2     <= w_op2;
        out_imm     <= w_imm;
        out_rd      <= w_writesRd ? w_rd : '0;
        out_rd_we   <= w_rdWe;
        out_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch.
//
// The bench has a small register file, and a reference model that works
// directly from the RV32I field and immediate definitions. It runs a set of
// directed scenarios with hand-computed expectations, then a randomized run
// with a writeback queue that retires outstanding destinations.
module tb_operand_fetch;

  localparam int WIDTH = 32;
  localparam int SIZE  = 32;
  localparam int IDX   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             rf_rd1_en;
  logic [IDX-1:0]   rf_rd1_index;
  logic [WIDTH-1:0] rf_rd1_data;
  logic             rf_rd2_en;
  logic [IDX-1:0]   rf_rd2_index;
  logic [WIDTH-1:0] rf_rd2_data;
  logic             wb_en;
  logic [IDX-1:0]   wb_index;
  logic [WIDTH-1:0] wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [WIDTH-1:0] out_op1;
  logic [WIDTH-1:0] out_op2;
  logic [31:0]      out_imm;
  logic [IDX-1:0]   out_rd;
  logic             out_rd_we;
  logic             out_illegal;

  logic [WIDTH-1:0] benchRegs [SIZE];

  assign rf_rd1_data = benchRegs[rf_rd1_index];
  assign rf_rd2_data = benchRegs[rf_rd2_index];

  always #5 clk = ~clk;

  operand_fetch #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rd1_en(rf_rd1_en), .rf_rd1_index(rf_rd1_index), .rf_rd1_data(rf_rd1_data),
    .rf_rd2_en(rf_rd2_en), .rf_rd2_index(rf_rd2_index), .rf_rd2_data(rf_rd2_data),
    .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  typedef struct {
    bit          r1;
    bit          r2;
    bit          wr;
    bit          ill;
    logic [31:0] imm;
  } decode_t;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: the expected output register and scoreboard.
  logic             mValid;
  logic [31:0]      mPc, mInstr, mImm;
  logic [WIDTH-1:0] mOp1, mOp2;
  logic [IDX-1:0]   mRd;
  logic             mRdWe, mIll;
  bit               mPending [SIZE];

  // What the last cycle showed, for the directed checks and the random driver.
  logic             sawReady, sawRd1En;
  bit               lastAccept, lastWe;
  logic [IDX-1:0]   lastRd;
  logic [IDX-1:0]   wbQueue [$];

  // Decode straight from the ISA definition. Each immediate is built as a
  // weighted sum of its fields, with the sign bit counted as a negative weight.
  function automatic decode_t decodeModel(input logic [31:0] ins);
    decode_t d;
    logic [31:0] neg;
    d = '{default: '0};
    case (ins[6:0])
      7'h33: begin d.r1 = 1; d.r2 = 1; d.wr = 1; end
      7'h13, 7'h03, 7'h67: begin
        d.r1 = 1; d.wr = 1;
        neg = ins[31] ? 32'd2048 : 32'd0;
        d.imm = 32'(ins[30:20]) - neg;
      end
      7'h23: begin
        d.r1 = 1; d.r2 = 1;
        neg = ins[31] ? 32'd2048 : 32'd0;
        d.imm = 32'(ins[11:7]) + 32'(ins[30:25]) * 32'd32 - neg;
      end
      7'h63: begin
        d.r1 = 1; d.r2 = 1;
        neg = ins[31] ? 32'd4096 : 32'd0;
        d.imm = 32'(ins[11:8]) * 32'd2 + 32'(ins[30:25]) * 32'd32
              + 32'(ins[7]) * 32'd2048 - neg;
      end
      7'h37, 7'h17: begin
        d.wr = 1;
        d.imm = ins & 32'hFFFFF000;
      end
      7'h6F: begin
        d.wr = 1;
        neg = ins[31] ? 32'h00100000 : 32'd0;
        d.imm = 32'(ins[30:21]) * 32'd2 + 32'(ins[20]) * 32'd2048
              + 32'(ins[19:12]) * 32'd4096 - neg;
      end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // One comparison: count it, and report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and compare the DUT with the model before the
  // edge. Then cross the edge and advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic we, input logic [IDX-1:0] wi,
                               input logic [WIDTH-1:0] wd, input logic fl,
                               input logic ordy);
    decode_t d;
    logic [IDX-1:0] rs1, rs2, rd;
    bit u1, u2, w, f1, f2, blocked, acc;
    logic [WIDTH-1:0] v1, v2;
    in_valid = v; in_instr = ins; in_pc = pc;
    wb_en = we; wb_index = wi; wb_data = wd;
    flush = fl; out_ready = ordy;
    #1;
    d   = decodeModel(ins);
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    u1  = d.r1 && (rs1 != 0);
    u2  = d.r2 && (rs2 != 0);
    w   = d.wr && (rd != 0);
    f1  = we && (wi == rs1);
    f2  = we && (wi == rs2);
    v1  = !u1 ? '0 : (f1 ? wd : benchRegs[rs1]);
    v2  = !u2 ? '0 : (f2 ? wd : benchRegs[rs2]);
    blocked = (u1 && mPending[rs1] && !f1) || (u2 && mPending[rs2] && !f2) ||
              (w && mPending[rd]) || (mValid && !ordy) || fl;
    acc = v && !blocked;

    sawReady = in_ready;
    sawRd1En = rf_rd1_en;
    checkOutput("in_ready", 32'(in_ready), 32'(!blocked));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("out_pc", out_pc, mPc);
      checkOutput("out_instr", out_instr, mInstr);
      checkOutput("out_op1", out_op1, mOp1);
      checkOutput("out_op2", out_op2, mOp2);
      checkOutput("out_imm", out_imm, mImm);
      checkOutput("out_rd", 32'(out_rd), 32'(mRd));
      checkOutput("out_rd_we", 32'(out_rd_we), 32'(mRdWe));
      checkOutput("out_illegal", 32'(out_illegal), 32'(mIll));
    end
    if (v) begin
      checkOutput("rf_rd1_en", 32'(rf_rd1_en), 32'(u1));
      checkOutput("rf_rd2_en", 32'(rf_rd2_en), 32'(u2));
      if (u1) checkOutput("rf_rd1_index", 32'(rf_rd1_index), 32'(rs1));
      if (u2) checkOutput("rf_rd2_index", 32'(rf_rd2_index), 32'(rs2));
    end

    @(posedge clk);
    #1;
    if (we && (wi != 0)) mPending[wi] = 0;
    if (fl && mValid && mRdWe) mPending[mRd] = 0;
    if (acc && w) mPending[rd] = 1;
    if (we && (wi != 0)) benchRegs[wi] = wd;
    if (acc) begin
      mPc = pc; mInstr = ins; mOp1 = v1; mOp2 = v2; mImm = d.imm;
      mRd = d.wr ? rd : '0; mRdWe = w; mIll = d.ill;
    end
    mValid = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : mValid));
    lastAccept = acc; lastWe = w; lastRd = rd;
  endtask

  // Assert reset across one edge. Outputs must clear at once, before any
  // edge, and stay clear.
  task automatic resetDut();
    reset = 1'b1;
    #1;
    mValid = 0; mPc = 0; mInstr = 0; mOp1 = 0; mOp2 = 0; mImm = 0;
    mRd = 0; mRdWe = 0; mIll = 0;
    foreach (mPending[i]) mPending[i] = 0;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_pc", out_pc, 32'd0);
    checkOutput("rst out_instr", out_instr, 32'd0);
    checkOutput("rst out_op1", out_op1, 32'd0);
    checkOutput("rst out_op2", out_op2, 32'd0);
    checkOutput("rst out_imm", out_imm, 32'd0);
    checkOutput("rst out_rd", 32'(out_rd), 32'd0);
    checkOutput("rst out_rd_we", 32'(out_rd_we), 32'd0);
    checkOutput("rst out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst held out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randomInstr();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h33};
    ins = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] curInstr, curPc;
    logic        curValid, wbE, fl, ordy;
    logic [IDX-1:0]   wbI;
    logic [WIDTH-1:0] wbD;

    foreach (benchRegs[i]) benchRegs[i] = $urandom;
    benchRegs[0] = '0;
    benchRegs[1] = 32'd5;
    benchRegs[2] = 32'd7;

    // Reset while fetch is already offering ADD x3,x1,x2.
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100;
    wb_en = 0; wb_index = '0; wb_data = '0; flush = 0; out_ready = 1;
    #2;
    resetDut();
    applyStimulus(1, 32'h002081B3, 32'h100, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t1 accepted on first edge", 32'(sawReady), 32'd1);
    checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1 op1", out_op1, 32'd5);
    checkOutput("t1 op2", out_op2, 32'd7);
    checkOutput("t1 rd", 32'(out_rd), 32'd3);
    checkOutput("t1 rd_we", 32'(out_rd_we), 32'd1);

    // SUB x4,x3,x1 stalls on pending x3, then goes through on the forward.
    applyStimulus(1, 32'h40118233, 32'h104, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t2 RAW stall", 32'(sawReady), 32'd0);
    applyStimulus(1, 32'h40118233, 32'h104, 1, 5'd3, 32'h1234, 0, 1);
    checkOutput("t2 accept on wb", 32'(sawReady), 32'd1);
    checkOutput("t2 forwarded op1", out_op1, 32'h1234);
    checkOutput("t2 op2", out_op2, 32'd5);

    // ADDI x0,x0,-1, then ADD x5,x0,x0.
    applyStimulus(1, 32'hFFF00013, 32'h108, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t3 rf_rd1_en", 32'(sawRd1En), 32'd0);
    checkOutput("t3 rd_we", 32'(out_rd_we), 32'd0);
    checkOutput("t3 imm", out_imm, 32'hFFFFFFFF);
    applyStimulus(1, 32'h000002B3, 32'h10C, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t3 x0 no stall", 32'(sawReady), 32'd1);

    // Execute back-pressure for 3 cycles with a second instruction waiting.
    applyStimulus(1, 32'h00500313, 32'h110, 0, 5'd0, 32'd0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h00100413, 32'h114, 0, 5'd0, 32'd0, 0, 0);
      checkOutput("t4 held stall", 32'(sawReady), 32'd0);
      checkOutput("t4 held pc", out_pc, 32'h110);
    end
    applyStimulus(1, 32'h00100413, 32'h114, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t4 accept on ready", 32'(sawReady), 32'd1);
    checkOutput("t4 new pc", out_pc, 32'h114);
    checkOutput("t4 new imm", out_imm, 32'd1);

    // Flush a held LUI x7, then LUI x7 again without a WAW stall.
    applyStimulus(1, 32'h123453B7, 32'h118, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t5 lui imm", out_imm, 32'h12345000);
    applyStimulus(0, 32'h123453B7, 32'h11C, 0, 5'd0, 32'd0, 0, 0);
    applyStimulus(1, 32'h123453B7, 32'h11C, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("t5 no accept in flush", 32'(sawReady), 32'd0);
    checkOutput("t5 flushed out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 32'h123453B7, 32'h11C, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t5 no WAW after flush", 32'(sawReady), 32'd1);
    checkOutput("t5 pc", out_pc, 32'h11C);

    // Reset in the middle of a stall drops the held instruction and x7 pending.
    applyStimulus(1, 32'h123453B7, 32'h120, 0, 5'd0, 32'd0, 0, 0);
    checkOutput("t6 stalled", 32'(sawReady), 32'd0);
    resetDut();
    applyStimulus(1, 32'h123453B7, 32'h120, 0, 5'd0, 32'd0, 0, 1);
    checkOutput("t6 accept after reset", 32'(sawReady), 32'd1);

    // Randomized run. Fetch holds an instruction until it is accepted, and
    // writebacks mostly retire destinations in the order they were issued.
    resetDut();
    curValid = 0; curInstr = 0; curPc = 32'h1000; lastAccept = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(curValid && !lastAccept)) begin
        curValid = ($urandom_range(0, 3) != 0);
        curInstr = randomInstr();
        curPc    = curPc + 32'd4;
      end
      wbE = 0; wbI = '0; wbD = $urandom;
      if (wbQueue.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbE = 1; wbI = wbQueue.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        wbE = 1; wbI = 5'($urandom_range(0, 7));
      end
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      applyStimulus(curValid, curInstr, curPc, wbE, wbI, wbD, fl, ordy);
      if (lastAccept && lastWe) wbQueue.push_back(lastRd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Decode/operand-fetch pipeline stage that sits directly upstream of the register file and feeds the execute stage. It accepts one fetched instruction per cycle over a valid/ready handshake and decodes the rs1/rs2/rd fields and the immediate. It drives the register file read ports, forwards same-cycle writeback data, tracks outstanding destination writes in a per-register scoreboard, and stalls on unresolved hazards. Results are held in a single output pipeline register with a valid/ready handshake toward execute.

Parameters:
WIDTH, 32, data/operand width in bits.
SIZE, 32, number of architectural registers; index width IDX = $clog2(SIZE).

Ports:
clk  input  1  clock, all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage accepts the instruction this cycle.
in_instr  input  32  RV32I instruction word.
in_pc  input  32  PC of in_instr.
rf_rd1_en  output  1  register file read port 1 enable.
rf_rd1_index  output  IDX  register file read port 1 index (rs1).
rf_rd1_data  input  WIDTH  register file read port 1 data (combinational).
rf_rd2_en  output  1  register file read port 2 enable.
rf_rd2_index  output  IDX  register file read port 2 index (rs2).
rf_rd2_data  input  WIDTH  register file read port 2 data.
wb_en  input  1  writeback this cycle; same signal as the register file write enable.
wb_index  input  IDX  writeback destination.
wb_data  input  WIDTH  writeback value.
flush  input  1  squash the held output instruction.
out_valid  output  1  output register holds a valid instruction.
out_ready  input  1  execute consumes the output this cycle.
out_pc  output  32  registered PC.
out_instr  output  32  registered instruction word.
out_op1  output  WIDTH  rs1 value, or 0 if rs1 is unused.
out_op2  output  WIDTH  rs2 value, or 0 if rs2 is unused.
out_imm  output  32  sign-extended immediate, or 0.
out_rd  output  IDX  destination index.
out_rd_we  output  1  instruction writes rd.
out_illegal  output  1  opcode not recognised.

Behaviour:
- Decode is on opcode [6:0].
  - R 0110011: rs1, rs2, rd.
  - I 0010011 / 0000011 / 1100111: rs1, rd, I-imm.
  - S 0100011: rs1, rs2, S-imm.
  - B 1100011: rs1, rs2, B-imm.
  - U 0110111 / 0010111: rd, U-imm.
  - J 1101111: rd, J-imm.
  - Any other opcode: no reads, no write, imm 0, illegal = 1.
- Read enables are asserted only when the field is used and the index is nonzero; otherwise the operand is 0.
- A read index of 0 never creates a dependency.
- rd_we = 1 only when the format writes rd and rd != 0.
- Forwarding: if wb_en and wb_index == rsX != 0, the operand takes wb_data; otherwise it takes rf_rdX_data.
- Scoreboard: one pending bit per register.
  - Set on accept when rd_we = 1.
  - Cleared when wb_en and wb_index != 0.
  - If set and clear hit the same index in the same cycle, set wins.
- Stall (in_ready = 0) when any of these holds:
  - RAW: a used rsX is pending and not forwarded this cycle.
  - WAW: the decoded rd is pending (no wb exemption).
  - Output is occupied: out_valid = 1 and out_ready = 0.
  - flush = 1.
- Accept: in_valid and in_ready. Output registers load on the next edge, so decode-to-output latency is one cycle.
- Back-to-back throughput is one instruction per cycle when there are no hazards.
- out_valid:
  - Set on accept.
  - Cleared when out_ready = 1 and there is no accept in the same cycle.
  - Remains 1 when consume and accept coincide.
- Output payload is stable while out_valid = 1 and out_ready = 0.
- flush:
  - Clears out_valid on the next edge.
  - If the held instruction has out_rd_we = 1, its pending bit is cleared.
  - Nothing is accepted in a flush cycle.
  - flush has priority over out_ready.
- Reset (asynchronous):
  - out_valid = 0, all pending bits = 0.
  - out_pc, out_instr, out_op1, out_op2, out_imm, out_rd, out_rd_we, out_illegal = 0.
  - in_ready is combinational and follows the stall equation once reset is released.
- Reset mid-stall drops the held instruction and all scoreboard state.

Test Plan:
- Reset with a valid input held -> out_valid = 0, all outputs 0, no pending bits; after release the ADD is accepted on the first edge.
- ADD x3,x1,x2 with rf data 5/7 and out_ready = 1 -> one cycle later out_valid = 1, op1 = 5, op2 = 7, rd = 3, rd_we = 1; x3 is pending.
- ADD x3 then SUB x4,x3,x1 with no wb -> in_ready = 0. When wb_en = 1, wb_index = 3, wb_data = 0x1234, SUB is accepted the same cycle with op1 = 0x1234.
- ADDI x0,x0,-1 -> rd_we = 0, imm = 0xFFFFFFFF, rf_rd1_en = 0, no pending bit set; a following ADD x5,x0,x0 does not stall.
- out_ready = 0 for 3 cycles with a second instruction waiting -> payload is held and in_ready = 0; the second instruction is accepted in the cycle out_ready = 1.
- Holding LUI x7 with out_ready = 0, assert flush -> out_valid = 0 next cycle, x7 pending cleared, and a following LUI x7 is accepted without a WAW stall.
